// File: rtl/jk_pkg.sv
// jk_pkg: shared FSM states, settle counter width and the per-bit JK excitation function.
package jk_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;
  // Returns {j,k} driving one flop from cur to nxt; dc fills the don't-care input.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt, input logic dc);
    return cur ? {dc, ~nxt} : {nxt, dc};
  endfunction
endpackage

// File: rtl/jk_excite_driver_if.sv
// jk_excite_driver_if: target word valid/ready handshake.
interface jk_excite_driver_if #(parameter int WIDTH = 4);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master(output valid, output data, input ready);
  modport slave(input valid, input data, output ready);
endinterface

// File: rtl/jk_target_skid.sv
// jk_target_skid: 2-entry FIFO buffering targets so they can arrive back-to-back.
module jk_target_skid #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  assign dout = mem[rp];
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: drives a JK flop bank toward requested targets with one-cycle excitation pulses.
// Define JK_FEEDBACK_CHECK_EN to add the q_fb input and sticky err output.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               SETTLE_CYCLES = 2,
  parameter bit               DC_MODE       = 1'b0,
  parameter logic [WIDTH-1:0] RESET_STATE   = '0
) (
  input  logic               clk,
  input  logic               rst,
  jk_excite_driver_if.slave  tgt,
  output logic [WIDTH-1:0]   j,
  output logic [WIDTH-1:0]   k,
  output logic [WIDTH-1:0]   q_model,
  output logic               done
`ifdef JK_FEEDBACK_CHECK_EN
  ,
  input  logic [WIDTH-1:0]   q_fb,
  output logic               err
`endif
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] head, j_n, k_n;
  logic push, pop, full, empty, ready_q, last;
  assign push = tgt.valid & ready_q;
  assign tgt.ready = ready_q;
  assign last = (state == SETTLE) && (cnt == '0);
  assign done = last;
  jk_target_skid #(.WIDTH(WIDTH)) u_skid (
    .clk, .rst, .push, .pop, .din(tgt.data), .dout(head), .full, .empty
  );
  always_comb begin
    pop = ~empty & ((state == IDLE) | last);
    state_n = pop ? APPLY : (state == APPLY) ? SETTLE : last ? IDLE : state;
  end
  always_comb begin
    j_n = '0;
    k_n = '0;
    for (int i = 0; i < WIDTH; i++) {j_n[i], k_n[i]} = jk_excite(q_model[i], head[i], DC_MODE);
  end
  // j/k are registered on entry to APPLY so they are nonzero for exactly that one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      j <= '0;
      k <= '0;
      q_model <= RESET_STATE;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == APPLY) ? CNT_W'(SETTLE_CYCLES - 1) : cnt - CNT_W'(state == SETTLE);
      j <= pop ? j_n : '0;
      k <= pop ? k_n : '0;
      if (pop) q_model <= head;
      ready_q <= ~(full ? ~pop : (~empty & push & ~pop));
    end
  end
`ifdef JK_FEEDBACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else err <= err | (last & (q_fb != q_model));
  end
`endif
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: directed vectors for set/reset (u0) and toggle-form (u1) drivers.
module tb_jk_excite_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  jk_excite_driver_if #(.WIDTH(4)) if0 ();
  jk_excite_driver_if #(.WIDTH(4)) if1 ();
  logic [3:0] j0, k0, q0, j1, k1, q1;
  logic d0, d1;
`ifdef JK_FEEDBACK_CHECK_EN
  logic [3:0] fb0 = 4'b0000;
  logic e0, e1;
`endif
  jk_excite_driver #(.WIDTH(4), .SETTLE_CYCLES(2), .DC_MODE(1'b0), .RESET_STATE(4'b0000)) u0 (
    .clk(clk), .rst(rst), .tgt(if0), .j(j0), .k(k0), .q_model(q0), .done(d0)
`ifdef JK_FEEDBACK_CHECK_EN
    , .q_fb(fb0), .err(e0)
`endif
  );
  jk_excite_driver #(.WIDTH(4), .SETTLE_CYCLES(2), .DC_MODE(1'b1), .RESET_STATE(4'b0000)) u1 (
    .clk(clk), .rst(rst), .tgt(if1), .j(j1), .k(k1), .q_model(q1), .done(d1)
`ifdef JK_FEEDBACK_CHECK_EN
    , .q_fb(4'b0000), .err(e1)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic wait_done0(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = d0;
    end
  endtask
  logic [3:0] ej [11] = '{4'h0, 4'b0001, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0};
  logic [3:0] ek [11] = '{4'h0, 4'b0110, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic ed [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  logic er [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic [3:0] b2b [3] = '{4'b0001, 4'b0011, 4'b0111};
  bit seen;
  initial begin
    if0.valid = 1'b0;
    if0.data = 4'b0000;
    if1.valid = 1'b0;
    if1.data = 4'b0000;
    repeat (3) tick();
    check("rst_j", j0, 4'b0000);
    check("rst_k", k0, 4'b0000);
    check("rst_q", q0, 4'b0000);
    check("rst_ready", if0.ready, 1'b0);
    check("rst_done", d0, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_rise", if0.ready, 1'b1);
    if0.valid = 1'b1;
    if0.data = 4'b1010;
    if1.valid = 1'b1;
    if1.data = 4'b1010;
    tick();
    if0.valid = 1'b0;
    if1.valid = 1'b0;
    check("t2_pre_j", j0, 4'b0000);
    tick();
    check("t2_j", j0, 4'b1010);
    check("t2_k", k0, 4'b0000);
    check("t2_j_dc1", j1, 4'b1010);
    check("t2_k_dc1", k1, 4'b1111);
    check("t2_q", q0, 4'b1010);
    tick();
    check("t2_s1_j", j0, 4'b0000);
    check("t2_s1_k_dc1", k1, 4'b0000);
    check("t2_s1_done", d0, 1'b0);
    tick();
    check("t2_done", d0, 1'b1);
    check("t2_done_dc1", d1, 1'b1);
    tick();
    check("t2_done_pulse", d0, 1'b0);
    check("t2_q_final", q0, 4'b1010);
    if0.valid = 1'b1;
    if0.data = 4'b0110;
    if1.valid = 1'b1;
    if1.data = 4'b0110;
    tick();
    if0.valid = 1'b0;
    if1.valid = 1'b0;
    tick();
    check("t3_j_dc1", j1, 4'b1110);
    check("t3_k_dc1", k1, 4'b1101);
    check("t3_j_dc0", j0, 4'b0100);
    check("t3_k_dc0", k0, 4'b1000);
    tick();
    check("t3_s1_j_dc1", j1, 4'b0000);
    tick();
    check("t3_done_dc1", d1, 1'b1);
    tick();
    check("t3_q_dc1", q1, 4'b0110);
    check("t3_q_dc0", q0, 4'b0110);
    if0.valid = 1'b1;
    for (int t = 0; t < 11; t++) begin
      if (t < 3) if0.data = b2b[t];
      tick();
      if (t == 2) if0.valid = 1'b0;
      check($sformatf("b2b_j%0d", t), j0, ej[t]);
      check($sformatf("b2b_k%0d", t), k0, ek[t]);
      check($sformatf("b2b_done%0d", t), d0, ed[t]);
      check($sformatf("b2b_ready%0d", t), if0.ready, er[t]);
    end
    check("b2b_q", q0, 4'b0111);
    if0.valid = 1'b1;
    if0.data = 4'b1000;
    tick();
    if0.data = 4'b1100;
    tick();
    if0.valid = 1'b0;
    check("t5_apply_j", j0, 4'b1000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_j", j0, 4'b0000);
    check("t5_k", k0, 4'b0000);
    check("t5_q", q0, 4'b0000);
    check("t5_done", d0, 1'b0);
    check("t5_ready", if0.ready, 1'b0);
    tick();
    check("t5_ready_rise", if0.ready, 1'b1);
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("t5_idle_j%0d", t), j0, 4'b0000);
      check($sformatf("t5_idle_done%0d", t), d0, 1'b0);
    end
    check("t5_idle_q", q0, 4'b0000);
`ifdef JK_FEEDBACK_CHECK_EN
    fb0 = 4'b1110;
    if0.valid = 1'b1;
    if0.data = 4'b1111;
    tick();
    if0.valid = 1'b0;
    wait_done0(seen);
    check("t6_done_seen", seen, 1'b1);
    check("t6_err_pre", e0, 1'b0);
    tick();
    check("t6_err_set", e0, 1'b1);
    fb0 = 4'b0000;
    if0.valid = 1'b1;
    if0.data = 4'b0000;
    tick();
    if0.valid = 1'b0;
    wait_done0(seen);
    check("t6_done2_seen", seen, 1'b1);
    tick();
    check("t6_err_sticky", e0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_err_clear", e0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
